// File: rtl/tft_ctrl_gen_pkg.sv
// Purpose : shared definitions for the parametrised TFT timing generator.
// Latency : n/a (types, constants and a pure function only).
// Backpress: n/a.
// Contents: pattern mode encodings, stock timing sets for 480x272 and
//           800x480 panels, and the colour-bar table.
package tft_ctrl_gen_pkg;

    typedef enum logic [1:0] {
        MODE_EXT   = 2'b00,
        MODE_BARS  = 2'b01,
        MODE_GRID  = 2'b10,
        MODE_BLACK = 2'b11
    } mode_e;

    // 480x272 panel (typical 4.3" RGB glass)
    localparam int T480_H_SYNC   = 41;
    localparam int T480_H_BACK   = 2;
    localparam int T480_H_ACTIVE = 480;
    localparam int T480_H_FRONT  = 2;
    localparam int T480_V_SYNC   = 10;
    localparam int T480_V_BACK   = 2;
    localparam int T480_V_ACTIVE = 272;
    localparam int T480_V_FRONT  = 2;

    // 800x480 panel (typical 7" RGB glass, H_TOTAL 1056, V_TOTAL 525)
    localparam int T800_H_SYNC   = 40;
    localparam int T800_H_BACK   = 46;
    localparam int T800_H_ACTIVE = 800;
    localparam int T800_H_FRONT  = 170;
    localparam int T800_V_SYNC   = 10;
    localparam int T800_V_BACK   = 23;
    localparam int T800_V_ACTIVE = 480;
    localparam int T800_V_FRONT  = 12;

    localparam int NUM_BARS = 8;

    // Bar colour as {r_on, g_on, b_on}; each set bit drives its field full-scale.
    function automatic logic [2:0] bar_colour(input logic [2:0] idx);
        logic [2:0] c;
        case (idx)
            3'd0:    c = 3'b111; // white
            3'd1:    c = 3'b110; // yellow
            3'd2:    c = 3'b011; // cyan
            3'd3:    c = 3'b010; // green
            3'd4:    c = 3'b101; // magenta
            3'd5:    c = 3'b100; // red
            3'd6:    c = 3'b001; // blue
            default: c = 3'b000; // black
        endcase
        return c;
    endfunction

endpackage

// File: rtl/tft_ctrl_gen_pattern.sv
// Purpose : built-in test pattern pixel (colour bars / grid / black) for the TFT generator.
// Latency : one register stage, matching an external source answering Data_req.
// Backpress: none -- evaluated every cycle from the stage-1 raster position.
// Ports: clk_i/rst_n_i clock and async active-low reset; hcount_i active-area x;
//        vcount_lo_i low nibble of active-area y; mode_i latched mode; pixel_o pattern pixel.
module tft_pattern_gen
    import tft_ctrl_gen_pkg::*;
#(
    parameter  int R_W      = 5,
    parameter  int G_W      = 6,
    parameter  int B_W      = 5,
    parameter  int H_ACTIVE = 800,
    parameter  int CNT_W    = 11,
    localparam int DATA_W   = R_W + G_W + B_W
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [CNT_W-1:0]  hcount_i,
    input  logic [3:0]        vcount_lo_i,
    input  logic [1:0]        mode_i,
    output logic [DATA_W-1:0] pixel_o
);

    localparam int BAR_W = H_ACTIVE / NUM_BARS;

    logic [2:0]        bar_idx;
    logic [2:0]        bar_rgb;
    logic              grid_on;
    logic [DATA_W-1:0] pixel_d;
    logic [DATA_W-1:0] pixel_q;

    always_comb begin
        // Threshold chain instead of a divide; the last bar keeps any remainder.
        bar_idx = '0;
        for (int k = 1; k < NUM_BARS; k++) begin
            if (hcount_i >= CNT_W'(k * BAR_W)) begin
                bar_idx = 3'(k);
            end
        end
        bar_rgb = bar_colour(bar_idx);
        grid_on = (hcount_i[3:0] == 4'd0) || (vcount_lo_i == 4'd0);

        pixel_d = '0;
        case (mode_e'(mode_i))
            MODE_BARS: pixel_d = {{R_W{bar_rgb[2]}}, {G_W{bar_rgb[1]}}, {B_W{bar_rgb[0]}}};
            MODE_GRID: pixel_d = {DATA_W{grid_on}};
            default:   pixel_d = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pixel_q <= '0;
        end else begin
            pixel_q <= pixel_d;
        end
    end

    assign pixel_o = pixel_q;

endmodule

// File: rtl/tft_ctrl_gen.sv
// Purpose : parametrised RGB parallel panel timing generator with pixel request, patterns and backlight PWM.
// Latency : Data_req/Hcount/Vcount one cycle after the raster counters; HS/VS/DE/RGB one cycle later still.
// Backpress: none -- free-running raster; the source must answer Data_req with exactly one register stage.
// Ports: Clk33M/Rst_n clock and async reset; Data_in source pixel; Mode pattern select;
//        Disp_en display enable; Pwm_duty backlight duty; Data_req/Hcount/Vcount pixel request;
//        Frame_start frame pulse; TFT_* panel pins.
module tft_ctrl_gen
    import tft_ctrl_gen_pkg::*;
#(
    parameter  int   R_W      = 5,
    parameter  int   G_W      = 6,
    parameter  int   B_W      = 5,
    parameter  int   H_SYNC   = 40,
    parameter  int   H_BACK   = 46,
    parameter  int   H_ACTIVE = 800,
    parameter  int   H_FRONT  = 170,
    parameter  int   V_SYNC   = 10,
    parameter  int   V_BACK   = 23,
    parameter  int   V_ACTIVE = 480,
    parameter  int   V_FRONT  = 12,
    parameter  logic HS_POL   = 1'b0,
    parameter  logic VS_POL   = 1'b0,
    parameter  int   CNT_W    = 11,
    parameter  int   PWM_DIV  = 4,
    localparam int   DATA_W   = R_W + G_W + B_W
) (
    input  logic              Clk33M,
    input  logic              Rst_n,
    input  logic [DATA_W-1:0] Data_in,
    input  logic [1:0]        Mode,
    input  logic              Disp_en,
    input  logic [7:0]        Pwm_duty,
    output logic              Data_req,
    output logic [CNT_W-1:0]  Hcount,
    output logic [CNT_W-1:0]  Vcount,
    output logic              Frame_start,
    output logic [DATA_W-1:0] TFT_rgb,
    output logic              TFT_hs,
    output logic              TFT_vs,
    output logic              TFT_de,
    output logic              TFT_clk,
    output logic              TFT_pwm
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int H_ST    = H_SYNC + H_BACK;
    localparam int H_END   = H_ST + H_ACTIVE;
    localparam int V_ST    = V_SYNC + V_BACK;
    localparam int V_END   = V_ST + V_ACTIVE;
    localparam int PSC_W   = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

    // stage 0: raster counters and frame-latched controls
    logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [1:0]       mode_l_q, mode_l_d;
    logic             en_l_q, en_l_d;
    logic             h_wrap, v_wrap, at_origin, active;
    // stage 1: request side
    logic             data_req_q, data_req_d;
    logic [CNT_W-1:0] hcount_q, hcount_d, vcount_q, vcount_d;
    logic             frame_start_q;
    logic             hs1_q, hs1_d, vs1_q, vs1_d;
    // stage 2: panel side
    logic             de_q, hs2_q, vs2_q;
    logic [DATA_W-1:0] pat_pixel, pixel_sel;
    // backlight PWM
    logic [PSC_W-1:0] psc_q, psc_d;
    logic [7:0]       pwm_cnt_q, pwm_cnt_d, duty_l_q, duty_l_d;
    logic             psc_wrap, pwm_q, pwm_d;

    always_comb begin
        h_wrap    = (h_cnt_q == CNT_W'(H_TOTAL - 1));
        v_wrap    = (v_cnt_q == CNT_W'(V_TOTAL - 1));
        at_origin = (h_cnt_q == '0) && (v_cnt_q == '0);
        active    = (h_cnt_q >= CNT_W'(H_ST)) && (h_cnt_q < CNT_W'(H_END)) &&
                    (v_cnt_q >= CNT_W'(V_ST)) && (v_cnt_q < CNT_W'(V_END));

        h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
        end

        // Controls only change at the frame origin so a frame never tears.
        mode_l_d = at_origin ? Mode    : mode_l_q;
        en_l_d   = at_origin ? Disp_en : en_l_q;

        data_req_d = active & en_l_q;
        hcount_d   = active ? h_cnt_q - CNT_W'(H_ST) : '0;
        vcount_d   = active ? v_cnt_q - CNT_W'(V_ST) : '0;
        hs1_d      = (h_cnt_q < CNT_W'(H_SYNC)) ? HS_POL : ~HS_POL;
        vs1_d      = (v_cnt_q < CNT_W'(V_SYNC)) ? VS_POL : ~VS_POL;

        psc_wrap  = (psc_q == PSC_W'(PWM_DIV - 1));
        psc_d     = psc_wrap ? '0 : psc_q + 1'b1;
        pwm_cnt_d = psc_wrap ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
        // New duty only at the period boundary, so a period is never cut short.
        duty_l_d  = (psc_wrap && (pwm_cnt_q == 8'hFF)) ? Pwm_duty : duty_l_q;
        pwm_d     = (pwm_cnt_q < duty_l_q);
    end

    always_ff @(posedge Clk33M or negedge Rst_n) begin
        if (!Rst_n) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            mode_l_q      <= MODE_EXT;
            en_l_q        <= 1'b1;
            data_req_q    <= 1'b0;
            hcount_q      <= '0;
            vcount_q      <= '0;
            frame_start_q <= 1'b0;
            hs1_q         <= ~HS_POL;
            vs1_q         <= ~VS_POL;
            de_q          <= 1'b0;
            hs2_q         <= ~HS_POL;
            vs2_q         <= ~VS_POL;
            psc_q         <= '0;
            pwm_cnt_q     <= '0;
            duty_l_q      <= '0;
            pwm_q         <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            mode_l_q      <= mode_l_d;
            en_l_q        <= en_l_d;
            data_req_q    <= data_req_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            frame_start_q <= at_origin;
            hs1_q         <= hs1_d;
            vs1_q         <= vs1_d;
            de_q          <= data_req_q;
            hs2_q         <= hs1_q;
            vs2_q         <= vs1_q;
            psc_q         <= psc_d;
            pwm_cnt_q     <= pwm_cnt_d;
            duty_l_q      <= duty_l_d;
            pwm_q         <= pwm_d;
        end
    end

    tft_pattern_gen #(
        .R_W      (R_W),
        .G_W      (G_W),
        .B_W      (B_W),
        .H_ACTIVE (H_ACTIVE),
        .CNT_W    (CNT_W)
    ) u_pattern (
        .clk_i       (Clk33M),
        .rst_n_i     (Rst_n),
        .hcount_i    (hcount_q),
        .vcount_lo_i (vcount_q[3:0]),
        .mode_i      (mode_l_q),
        .pixel_o     (pat_pixel)
    );

    // Both pixel sources already carry their own register stage aligned with
    // de_q (source flop / pattern flop), so only the gating mux sits here.
    assign pixel_sel = (mode_e'(mode_l_q) == MODE_EXT) ? Data_in : pat_pixel;

    assign Data_req    = data_req_q;
    assign Hcount      = hcount_q;
    assign Vcount      = vcount_q;
    assign Frame_start = frame_start_q;
    assign TFT_de      = de_q;
    assign TFT_rgb     = de_q ? pixel_sel : '0;
    assign TFT_hs      = hs2_q;
    assign TFT_vs      = vs2_q;
    // Inverted clock puts the panel's rising sample edge mid-way through each pixel.
    assign TFT_clk     = ~Clk33M;
    assign TFT_pwm     = pwm_q;

endmodule

// File: tb/tb_tft_ctrl_gen.sv
// Purpose : directed self-checking bench for tft_ctrl_gen on a tiny 14x7 raster.
// Latency : n/a.
// Backpress: n/a.
module tb_tft_ctrl_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] data_in;
    logic [1:0]  mode;
    logic        disp_en;
    logic [7:0]  pwm_duty;
    logic        data_req;
    logic [10:0] hcount, vcount;
    logic        frame_start;
    logic [15:0] tft_rgb;
    logic        tft_hs, tft_vs, tft_de, tft_clk, tft_pwm;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] bars_exp [8];

    // grab_frame results
    int g_de, g_nz, g_req, g_hs_low, g_hs_fall, g_vs_low, g_de_rise, g_bad_run, g_bad_align;
    logic [15:0] px_q [$];

    tft_ctrl_gen #(
        .H_SYNC(2), .H_BACK(2), .H_ACTIVE(8), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(1), .V_ACTIVE(4), .V_FRONT(1),
        .PWM_DIV(1)
    ) dut (
        .Clk33M      (clk),
        .Rst_n       (rst_n),
        .Data_in     (data_in),
        .Mode        (mode),
        .Disp_en     (disp_en),
        .Pwm_duty    (pwm_duty),
        .Data_req    (data_req),
        .Hcount      (hcount),
        .Vcount      (vcount),
        .Frame_start (frame_start),
        .TFT_rgb     (tft_rgb),
        .TFT_hs      (tft_hs),
        .TFT_vs      (tft_vs),
        .TFT_de      (tft_de),
        .TFT_clk     (tft_clk),
        .TFT_pwm     (tft_pwm)
    );

    always #5 clk = ~clk;

    // External source: one register stage answering Data_req with {y,x}.
    logic [15:0] src_q = 16'h0;
    always @(posedge clk) begin
        if (data_req) src_q <= {vcount[7:0], hcount[7:0]};
    end
    assign data_in = src_q;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (frame_start === 1'b1) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    // Samples one full 98-cycle frame at negedges, starting at a Frame_start cycle.
    task automatic grab_frame(input int chg_at, input logic [1:0] chg_mode);
        bit ok;
        logic p_de, p_req, p_hs;
        int run;
        wait_frame(ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL frame_start_timeout: got none in 200 cycles, required a pulse");
        end
        g_de = 0; g_nz = 0; g_req = 0; g_hs_low = 0; g_hs_fall = 0; g_vs_low = 0;
        g_de_rise = 0; g_bad_run = 0; g_bad_align = 0; run = 0;
        px_q.delete();
        p_de = tft_de; p_req = data_req; p_hs = tft_hs;
        for (int i = 0; i < 98; i++) begin
            if (i == chg_at) mode = chg_mode;
            if (tft_de) begin g_de++; run++; px_q.push_back(tft_rgb); end
            if (tft_rgb != 16'h0) g_nz++;
            if (data_req) g_req++;
            if (!tft_hs) g_hs_low++;
            if (!tft_vs) g_vs_low++;
            if (!tft_hs && p_hs) g_hs_fall++;
            if (i > 0) begin
                if (tft_de && !p_de) g_de_rise++;
                if (!tft_de && p_de && run != 8) g_bad_run++;
                if (tft_de !== p_req) g_bad_align++;
            end
            if (!tft_de) run = 0;
            p_de = tft_de; p_req = data_req; p_hs = tft_hs;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (20) @(negedge clk);
        n_tests++; if (tft_hs !== 1'b1)      begin n_fail++; $display("FAIL rst_hs: got %b, required 1", tft_hs); end
        n_tests++; if (tft_vs !== 1'b1)      begin n_fail++; $display("FAIL rst_vs: got %b, required 1", tft_vs); end
        n_tests++; if (tft_de !== 1'b0)      begin n_fail++; $display("FAIL rst_de: got %b, required 0", tft_de); end
        n_tests++; if (tft_rgb !== 16'h0)    begin n_fail++; $display("FAIL rst_rgb: got %h, required 0000", tft_rgb); end
        n_tests++; if (data_req !== 1'b0)    begin n_fail++; $display("FAIL rst_req: got %b, required 0", data_req); end
        n_tests++; if (tft_pwm !== 1'b0)     begin n_fail++; $display("FAIL rst_pwm: got %b, required 0", tft_pwm); end
        n_tests++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL rst_fs: got %b, required 0", frame_start); end
        n_tests++; if (hcount !== 11'd0 || vcount !== 11'd0) begin n_fail++; $display("FAIL rst_count: got %0d/%0d, required 0/0", hcount, vcount); end
        n_tests++; if (tft_clk !== ~clk)     begin n_fail++; $display("FAIL tft_clk: got %b, required %b", tft_clk, ~clk); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (frame_start !== 1'b1) begin n_fail++; $display("FAIL fs_first: got %b, required 1", frame_start); end
        @(posedge clk); #1;
        n_tests++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL fs_second: got %b, required 0", frame_start); end
    endtask

    task automatic test_timing();
        grab_frame(-1, 2'b00);
        n_tests++; if (g_hs_low != 14)   begin n_fail++; $display("FAIL hs_low: got %0d, required 14", g_hs_low); end
        n_tests++; if (g_hs_fall != 7)   begin n_fail++; $display("FAIL hs_pulses: got %0d, required 7", g_hs_fall); end
        n_tests++; if (g_vs_low != 14)   begin n_fail++; $display("FAIL vs_low: got %0d, required 14", g_vs_low); end
        n_tests++; if (g_de != 32)       begin n_fail++; $display("FAIL de_count: got %0d, required 32", g_de); end
        n_tests++; if (g_de_rise != 4)   begin n_fail++; $display("FAIL de_lines: got %0d, required 4", g_de_rise); end
        n_tests++; if (g_bad_run != 0)   begin n_fail++; $display("FAIL de_run: got %0d bad runs, required 0", g_bad_run); end
        n_tests++; if (g_bad_align != 0) begin n_fail++; $display("FAIL req_lead: got %0d misaligned cycles, required 0", g_bad_align); end
        n_tests++; if (g_req != 32)      begin n_fail++; $display("FAIL req_count: got %0d, required 32", g_req); end
    endtask

    task automatic check_ext_frame(input string tag);
        logic [15:0] exp;
        n_tests++;
        if (px_q.size() != 32) begin
            n_fail++; $display("FAIL %s_size: got %0d, required 32", tag, px_q.size());
        end else begin
            for (int i = 0; i < 32; i++) begin
                exp = {8'(i / 8), 8'(i % 8)};
                n_tests++;
                if (px_q[i] !== exp) begin n_fail++; $display("FAIL %s_px%0d: got %h, required %h", tag, i, px_q[i], exp); end
            end
        end
    endtask

    task automatic test_ext_frame();
        grab_frame(-1, 2'b00);
        check_ext_frame("ext");
        n_tests++; if (px_q.size() == 0 || px_q[0] !== 16'h0000) begin n_fail++; $display("FAIL ext_first: required 0000"); end
        n_tests++; if (px_q.size() == 0 || px_q[px_q.size()-1] !== 16'h0307) begin n_fail++; $display("FAIL ext_last: required 0307"); end
    endtask

    task automatic test_mode_switch();
        grab_frame(40, 2'b01);
        check_ext_frame("switch_cur");
        grab_frame(-1, 2'b00);
        n_tests++;
        if (px_q.size() != 32) begin
            n_fail++; $display("FAIL bars_size: got %0d, required 32", px_q.size());
        end else begin
            for (int i = 0; i < 32; i++) begin
                n_tests++;
                if (px_q[i] !== bars_exp[i % 8]) begin n_fail++; $display("FAIL bars_px%0d: got %h, required %h", i, px_q[i], bars_exp[i % 8]); end
            end
        end
    endtask

    task automatic test_grid_black();
        logic [15:0] exp;
        mode = 2'b10;
        grab_frame(-1, 2'b00);
        grab_frame(-1, 2'b00);
        n_tests++;
        if (px_q.size() != 32) begin
            n_fail++; $display("FAIL grid_size: got %0d, required 32", px_q.size());
        end else begin
            for (int i = 0; i < 32; i++) begin
                exp = (i < 8 || (i % 8) == 0) ? 16'hFFFF : 16'h0000;
                n_tests++;
                if (px_q[i] !== exp) begin n_fail++; $display("FAIL grid_px%0d: got %h, required %h", i, px_q[i], exp); end
            end
        end
        mode = 2'b11;
        grab_frame(-1, 2'b00);
        grab_frame(-1, 2'b00);
        n_tests++; if (g_de != 32) begin n_fail++; $display("FAIL black_de: got %0d, required 32", g_de); end
        n_tests++; if (g_nz != 0)  begin n_fail++; $display("FAIL black_rgb: got %0d nonzero, required 0", g_nz); end
    endtask

    task automatic test_disp_en();
        mode = 2'b00;
        disp_en = 1'b0;
        grab_frame(-1, 2'b00);
        grab_frame(-1, 2'b00);
        n_tests++; if (g_de != 0)       begin n_fail++; $display("FAIL blank_de: got %0d, required 0", g_de); end
        n_tests++; if (g_nz != 0)       begin n_fail++; $display("FAIL blank_rgb: got %0d nonzero, required 0", g_nz); end
        n_tests++; if (g_req != 0)      begin n_fail++; $display("FAIL blank_req: got %0d, required 0", g_req); end
        n_tests++; if (g_hs_low != 14)  begin n_fail++; $display("FAIL blank_hs: got %0d, required 14", g_hs_low); end
        n_tests++; if (g_vs_low != 14)  begin n_fail++; $display("FAIL blank_vs: got %0d, required 14", g_vs_low); end
        disp_en = 1'b1;
        grab_frame(-1, 2'b00);
        grab_frame(-1, 2'b00);
        n_tests++; if (g_de != 32)      begin n_fail++; $display("FAIL unblank_de: got %0d, required 32", g_de); end
    endtask

    task automatic test_pwm();
        int hi [5];
        int exp [5];
        exp[0] = 0; exp[1] = 64; exp[2] = 64; exp[3] = 128; exp[4] = 0;
        for (int w = 0; w < 5; w++) hi[w] = 0;
        @(negedge clk);
        rst_n = 1'b0;
        pwm_duty = 8'd64;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 1280; k++) begin
            @(posedge clk); #1;
            if (tft_pwm) hi[(k - 1) / 256]++;
            if (k == 600) pwm_duty = 8'd128;
            if (k == 800) pwm_duty = 8'd0;
        end
        for (int w = 0; w < 5; w++) begin
            n_tests++;
            if (hi[w] != exp[w]) begin n_fail++; $display("FAIL pwm_period%0d: got %0d high, required %0d", w, hi[w], exp[w]); end
        end
    endtask

    task automatic test_async_reset();
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (tft_de === 1'b1) seen = 1'b1;
        end
        n_tests++;
        if (!seen) begin n_fail++; $display("FAIL areset_de_timeout: got no de in 200 cycles, required de"); end
        #1 rst_n = 1'b0;
        #1;
        n_tests++; if (tft_hs !== 1'b1 || tft_vs !== 1'b1) begin n_fail++; $display("FAIL areset_sync: got hs=%b vs=%b, required 1/1", tft_hs, tft_vs); end
        n_tests++; if (tft_de !== 1'b0 || tft_rgb !== 16'h0) begin n_fail++; $display("FAIL areset_de_rgb: got %b/%h, required 0/0000", tft_de, tft_rgb); end
        n_tests++; if (data_req !== 1'b0 || frame_start !== 1'b0) begin n_fail++; $display("FAIL areset_req_fs: got %b/%b, required 0/0", data_req, frame_start); end
        n_tests++; if (hcount !== 11'd0 || vcount !== 11'd0) begin n_fail++; $display("FAIL areset_count: got %0d/%0d, required 0/0", hcount, vcount); end
        n_tests++; if (tft_pwm !== 1'b0) begin n_fail++; $display("FAIL areset_pwm: got %b, required 0", tft_pwm); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; mode = 2'b00; disp_en = 1'b1; pwm_duty = 8'd0;
        bars_exp[0] = 16'hFFFF; bars_exp[1] = 16'hFFE0; bars_exp[2] = 16'h07FF; bars_exp[3] = 16'h07E0;
        bars_exp[4] = 16'hF81F; bars_exp[5] = 16'hF800; bars_exp[6] = 16'h001F; bars_exp[7] = 16'h0000;
        test_reset();
        test_timing();
        test_ext_frame();
        test_mode_switch();
        test_grid_black();
        test_disp_en();
        test_pwm();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
